// File: rtl/xadc_drp_master_pkg.sv
// ============================================================================
// Module  : xadc_drp_pkg
// Purpose : Shared widths, DRP addresses and FSM encodings for xadc_drp_master
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package xadc_drp_pkg;

  localparam int DRP_AW    = 7;
  localparam int DRP_DW    = 16;
  localparam int ADC_W     = 12;
  localparam int CH_W      = 5;
  localparam int NUM_CFG   = 3;
  localparam int CFG_IDX_W = 2;

  localparam logic [DRP_AW-1:0]    DRP_ADDR_CFG0 = 7'h40;
  localparam logic [CFG_IDX_W-1:0] CFG_LAST      = 2'(NUM_CFG - 1);

  typedef logic [2:0] drp_state_t;

  localparam drp_state_t ST_CFG_REQ  = 3'd0;
  localparam drp_state_t ST_CFG_WAIT = 3'd1;
  localparam drp_state_t ST_IDLE     = 3'd2;
  localparam drp_state_t ST_RD_REQ   = 3'd3;
  localparam drp_state_t ST_RD_WAIT  = 3'd4;

  function automatic logic [DRP_AW-1:0] cfg_addr(input logic [CFG_IDX_W-1:0] idx);
    return DRP_ADDR_CFG0 + {{(DRP_AW-CFG_IDX_W){1'b0}}, idx};
  endfunction

endpackage

`default_nettype wire

// File: rtl/xadc_drp_master_if.sv
// ============================================================================
// Module  : xadc_drp_master_if
// Purpose : DRP bus between the DRP initiator (master) and XADC wrapper (slave)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface xadc_drp_master_if;
  import xadc_drp_pkg::*;

  logic [DRP_AW-1:0] daddr_out;
  logic              den_out;
  logic              dwe_out;
  logic [DRP_DW-1:0] di_out;
  logic [DRP_DW-1:0] drp_do_in;
  logic              drdy_in;

  modport master (
    output daddr_out, den_out, dwe_out, di_out,
    input  drp_do_in, drdy_in
  );

  modport slave (
    input  daddr_out, den_out, dwe_out, di_out,
    output drp_do_in, drdy_in
  );

endinterface

`default_nettype wire

// File: rtl/xadc_drp_master.sv
// ============================================================================
// Module  : xadc_drp_master
// Purpose : Writes XADC config regs 0x40-0x42, then reads one result per EOC.
//           Optional DRP wait timeout enabled by macro DRP_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module xadc_drp_master
  import xadc_drp_pkg::*;
#(
  parameter logic [DRP_DW-1:0] CFG0_VAL = 16'h0010,
  parameter logic [DRP_DW-1:0] CFG1_VAL = 16'h3F0F,
  parameter logic [DRP_DW-1:0] CFG2_VAL = 16'h0400
`ifdef DRP_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input  wire logic             dclk_in,
  input  wire logic             reset_in,
  input  wire logic             eoc_in,
  input  wire logic [CH_W-1:0]  channel_in,
  xadc_drp_master_if.master     drp,
  output logic      [ADC_W-1:0] sample_out,
  output logic      [CH_W-1:0]  sample_ch_out,
  output logic                  sample_valid_out,
  output logic                  cfg_done_out,
  output logic                  busy_out,
  output logic                  overrun_out,
  output logic                  timeout_out
);

  drp_state_t            state_q,     state_d;
  logic [CFG_IDX_W-1:0]  cfg_idx_q,   cfg_idx_d;
  logic [CH_W-1:0]       ch_q,        ch_d;
  logic                  pending_q,   pending_d;
  logic [CH_W-1:0]       pend_ch_q,   pend_ch_d;
  logic                  den_q,       den_d;
  logic                  dwe_q,       dwe_d;
  logic [DRP_AW-1:0]     daddr_q,     daddr_d;
  logic [DRP_DW-1:0]     di_q,        di_d;
  logic [ADC_W-1:0]      sample_q,    sample_d;
  logic [CH_W-1:0]       sample_ch_q, sample_ch_d;
  logic                  valid_q,     valid_d;
  logic                  cfg_done_q,  cfg_done_d;
  logic                  busy_q,      busy_d;
  logic                  overrun_q,   overrun_d;
  logic [DRP_DW-1:0]     cfg_val;
  logic                  timed_out;
  logic                  ack;
  wire                   do_lsb_unused = ^drp.drp_do_in[3:0];

  always_comb begin
    case (cfg_idx_d)
      2'd0:    cfg_val = CFG0_VAL;
      2'd1:    cfg_val = CFG1_VAL;
      default: cfg_val = CFG2_VAL;
    endcase
  end

  // A timeout is treated as an acknowledge without data.
  assign ack = drp.drdy_in | timed_out;

  always_comb begin
    state_d     = state_q;
    cfg_idx_d   = cfg_idx_q;
    ch_d        = ch_q;
    pending_d   = pending_q;
    pend_ch_d   = pend_ch_q;
    cfg_done_d  = cfg_done_q;
    sample_d    = sample_q;
    sample_ch_d = sample_ch_q;
    valid_d     = 1'b0;
    overrun_d   = 1'b0;

    // Only one EOC can queue behind an active read; any further one is lost.
    if (((state_q == ST_RD_REQ) || (state_q == ST_RD_WAIT)) && eoc_in) begin
      if (pending_q) begin
        overrun_d = 1'b1;
      end else begin
        pending_d = 1'b1;
        pend_ch_d = channel_in;
      end
    end

    case (state_q)
      ST_CFG_REQ: begin
        // First cycle out of reset has no strobe yet; leave once it is issued.
        if (den_q) state_d = ST_CFG_WAIT;
      end
      ST_CFG_WAIT: begin
        if (ack) begin
          if (cfg_idx_q == CFG_LAST) begin
            cfg_done_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            cfg_idx_d = cfg_idx_q + 2'd1;
            state_d   = ST_CFG_REQ;
          end
        end
      end
      ST_IDLE: begin
        if (eoc_in) begin
          ch_d    = channel_in;
          state_d = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (ack) begin
          if (drp.drdy_in) begin
            sample_d    = drp.drp_do_in[DRP_DW-1:DRP_DW-ADC_W];
            sample_ch_d = ch_q;
            valid_d     = 1'b1;
          end
          if (pending_d) begin
            pending_d = 1'b0;
            ch_d      = pend_ch_d;
            state_d   = ST_RD_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_CFG_REQ;
    endcase
  end

  // Bus outputs are registered from the next state so den aligns with REQ.
  always_comb begin
    den_d   = (state_d == ST_CFG_REQ) || (state_d == ST_RD_REQ);
    dwe_d   = (state_d == ST_CFG_REQ);
    busy_d  = (state_d != ST_IDLE);
    daddr_d = daddr_q;
    di_d    = di_q;
    if (state_d == ST_CFG_REQ) begin
      daddr_d = cfg_addr(cfg_idx_d);
      di_d    = cfg_val;
    end else if (state_d == ST_RD_REQ) begin
      daddr_d = {{(DRP_AW-CH_W){1'b0}}, ch_d};
    end
  end

  always_ff @(posedge dclk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q     <= ST_CFG_REQ;
      cfg_idx_q   <= '0;
      ch_q        <= '0;
      pending_q   <= 1'b0;
      pend_ch_q   <= '0;
      den_q       <= 1'b0;
      dwe_q       <= 1'b0;
      daddr_q     <= '0;
      di_q        <= '0;
      sample_q    <= '0;
      sample_ch_q <= '0;
      valid_q     <= 1'b0;
      cfg_done_q  <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_idx_q   <= cfg_idx_d;
      ch_q        <= ch_d;
      pending_q   <= pending_d;
      pend_ch_q   <= pend_ch_d;
      den_q       <= den_d;
      dwe_q       <= dwe_d;
      daddr_q     <= daddr_d;
      di_q        <= di_d;
      sample_q    <= sample_d;
      sample_ch_q <= sample_ch_d;
      valid_q     <= valid_d;
      cfg_done_q  <= cfg_done_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef DRP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt_q;
  logic             timeout_q;
  logic             in_wait;

  assign in_wait   = (state_q == ST_CFG_WAIT) || (state_q == ST_RD_WAIT);
  assign timed_out = in_wait && !drp.drdy_in && (wait_cnt_q == CNT_LAST);

  // Wait states are only ever entered from a REQ state, where the count is zero.
  always_ff @(posedge dclk_in or posedge reset_in) begin
    if (reset_in) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= in_wait ? wait_cnt_q + 1'b1 : '0;
      timeout_q  <= timed_out;
    end
  end

  assign timeout_out = timeout_q;
`else
  assign timed_out   = 1'b0;
  assign timeout_out = 1'b0;
`endif

  assign drp.den_out       = den_q;
  assign drp.dwe_out       = dwe_q;
  assign drp.daddr_out     = daddr_q;
  assign drp.di_out        = di_q;
  assign sample_out        = sample_q;
  assign sample_ch_out     = sample_ch_q;
  assign sample_valid_out  = valid_q;
  assign cfg_done_out      = cfg_done_q;
  assign busy_out          = busy_q;
  assign overrun_out       = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_xadc_drp_master.sv
// ============================================================================
// Module  : tb_xadc_drp_master
// Purpose : Directed self-checking bench for xadc_drp_master (DRP_TIMEOUT_EN aware)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xadc_drp_master;
  import xadc_drp_pkg::*;

  logic             dclk_in;
  logic             reset_in;
  logic             eoc_in;
  logic [CH_W-1:0]  channel_in;
  logic [ADC_W-1:0] sample_out;
  logic [CH_W-1:0]  sample_ch_out;
  logic             sample_valid_out;
  logic             cfg_done_out;
  logic             busy_out;
  logic             overrun_out;
  logic             timeout_out;

  int passed = 0;
  int checks = 0;

  xadc_drp_master_if drp ();

  xadc_drp_master dut (
    .dclk_in          (dclk_in),
    .reset_in         (reset_in),
    .eoc_in           (eoc_in),
    .channel_in       (channel_in),
    .drp              (drp.master),
    .sample_out       (sample_out),
    .sample_ch_out    (sample_ch_out),
    .sample_valid_out (sample_valid_out),
    .cfg_done_out     (cfg_done_out),
    .busy_out         (busy_out),
    .overrun_out      (overrun_out),
    .timeout_out      (timeout_out)
  );

  initial dclk_in = 1'b0;
  always #5 dclk_in = ~dclk_in;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish before 400000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge dclk_in);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) passed++;
    else begin
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      $error("%s check failed", tag);
    end
  endtask

  task automatic wait_den(input string tag);
    int n;
    n = 0;
    while (drp.den_out !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, " den"}, {31'd0, drp.den_out}, 32'd1);
  endtask

  // Checks one strobe, then answers with drdy 3 cycles after den; returns with drdy high.
  task automatic drp_txn(input string tag, input logic [6:0] a, input logic w,
                         input logic [15:0] d, input logic [15:0] rdata);
    wait_den(tag);
    check({tag, " addr"}, {25'd0, drp.daddr_out}, {25'd0, a});
    check({tag, " dwe"}, {31'd0, drp.dwe_out}, {31'd0, w});
    if (w) check({tag, " di"}, {16'd0, drp.di_out}, {16'd0, d});
    tick();
    check({tag, " den width"}, {31'd0, drp.den_out}, 32'd0);
    tick();
    tick();
    drp.drdy_in   = 1'b1;
    drp.drp_do_in = rdata;
  endtask

  task automatic ack_done();
    tick();
    drp.drdy_in   = 1'b0;
    drp.drp_do_in = 16'h0000;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " den"},     {31'd0, drp.den_out}, 32'd0);
    check({tag, " dwe"},     {31'd0, drp.dwe_out}, 32'd0);
    check({tag, " daddr"},   {25'd0, drp.daddr_out}, 32'd0);
    check({tag, " di"},      {16'd0, drp.di_out}, 32'd0);
    check({tag, " sample"},  {20'd0, sample_out}, 32'd0);
    check({tag, " ch"},      {27'd0, sample_ch_out}, 32'd0);
    check({tag, " valid"},   {31'd0, sample_valid_out}, 32'd0);
    check({tag, " cfgdone"}, {31'd0, cfg_done_out}, 32'd0);
    check({tag, " busy"},    {31'd0, busy_out}, 32'd0);
    check({tag, " overrun"}, {31'd0, overrun_out}, 32'd0);
    check({tag, " timeout"}, {31'd0, timeout_out}, 32'd0);
  endtask

  initial begin
    reset_in      = 1'b1;
    eoc_in        = 1'b0;
    channel_in    = 5'd0;
    drp.drdy_in   = 1'b0;
    drp.drp_do_in = 16'h0000;
    repeat (3) tick();
    check_all_zero("reset");

    // Release; an EOC before configuration must be ignored.
    reset_in   = 1'b0;
    eoc_in     = 1'b1;
    channel_in = 5'd5;
    tick();
    eoc_in = 1'b0;
    drp_txn("cfg0", 7'h40, 1'b1, 16'h0010, 16'h0000);
    ack_done();
    drp_txn("cfg1", 7'h41, 1'b1, 16'h3F0F, 16'h0000);
    ack_done();
    drp_txn("cfg2", 7'h42, 1'b1, 16'h0400, 16'h0000);
    check("cfgdone before ack", {31'd0, cfg_done_out}, 32'd0);
    ack_done();
    check("cfgdone after ack", {31'd0, cfg_done_out}, 32'd1);
    check("busy idle", {31'd0, busy_out}, 32'd0);
    repeat (3) tick();
    check("no stale read", {31'd0, drp.den_out}, 32'd0);
    check("no early overrun", {31'd0, overrun_out}, 32'd0);

    // Single read of channel 16.
    eoc_in     = 1'b1;
    channel_in = 5'd16;
    tick();
    eoc_in = 1'b0;
    check("rd latency den", {31'd0, drp.den_out}, 32'd1);
    drp_txn("rd16", 7'h10, 1'b0, 16'h0000, 16'hABC0);
    check("rd16 valid early", {31'd0, sample_valid_out}, 32'd0);
    ack_done();
    check("rd16 valid", {31'd0, sample_valid_out}, 32'd1);
    check("rd16 sample", {20'd0, sample_out}, 32'h0ABC);
    check("rd16 ch", {27'd0, sample_ch_out}, 32'd16);
    tick();
    check("rd16 valid width", {31'd0, sample_valid_out}, 32'd0);
    check("rd16 busy", {31'd0, busy_out}, 32'd0);

    // Two EOCs while a read of channel 7 is outstanding.
    eoc_in     = 1'b1;
    channel_in = 5'd7;
    tick();
    eoc_in = 1'b0;
    check("rd7 addr", {25'd0, drp.daddr_out}, 32'h07);
    tick();
    eoc_in     = 1'b1;
    channel_in = 5'd16;
    tick();
    channel_in = 5'd3;
    check("ovr first eoc", {31'd0, overrun_out}, 32'd0);
    tick();
    eoc_in = 1'b0;
    check("ovr second eoc", {31'd0, overrun_out}, 32'd1);
    tick();
    check("ovr width", {31'd0, overrun_out}, 32'd0);
    check("rd7 busy", {31'd0, busy_out}, 32'd1);
    drp.drdy_in   = 1'b1;
    drp.drp_do_in = 16'h1230;
    tick();
    drp.drdy_in   = 1'b0;
    drp.drp_do_in = 16'h0000;
    check("rd7 valid", {31'd0, sample_valid_out}, 32'd1);
    check("rd7 sample", {20'd0, sample_out}, 32'h0123);
    check("rd7 ch", {27'd0, sample_ch_out}, 32'd7);
    drp_txn("rdpend", 7'h10, 1'b0, 16'h0000, 16'h7770);
    ack_done();
    check("rdpend sample", {20'd0, sample_out}, 32'h0777);
    check("rdpend ch", {27'd0, sample_ch_out}, 32'd16);
    repeat (3) tick();
    check("dropped eoc no read", {31'd0, drp.den_out}, 32'd0);

    // EOC coinciding with drdy.
    eoc_in     = 1'b1;
    channel_in = 5'd2;
    tick();
    eoc_in = 1'b0;
    drp_txn("rd2", 7'h02, 1'b0, 16'h0000, 16'h5550);
    eoc_in     = 1'b1;
    channel_in = 5'd9;
    tick();
    eoc_in        = 1'b0;
    drp.drdy_in   = 1'b0;
    drp.drp_do_in = 16'h0000;
    check("coinc valid", {31'd0, sample_valid_out}, 32'd1);
    check("coinc sample", {20'd0, sample_out}, 32'h0555);
    check("coinc ch", {27'd0, sample_ch_out}, 32'd2);
    check("coinc overrun", {31'd0, overrun_out}, 32'd0);
    drp_txn("rd9", 7'h09, 1'b0, 16'h0000, 16'h0FF0);
    check("rd9 overrun", {31'd0, overrun_out}, 32'd0);
    ack_done();
    check("rd9 sample", {20'd0, sample_out}, 32'h00FF);
    check("rd9 ch", {27'd0, sample_ch_out}, 32'd9);

    // Reset during the wait for config index 1.
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    drp_txn("rcfg0", 7'h40, 1'b1, 16'h0010, 16'h0000);
    ack_done();
    wait_den("rcfg1");
    check("rcfg1 addr", {25'd0, drp.daddr_out}, 32'h41);
    tick();
    tick();
    reset_in = 1'b1;
    #1;
    check_all_zero("midreset");
    tick();
    tick();
    reset_in = 1'b0;
    drp_txn("again0", 7'h40, 1'b1, 16'h0010, 16'h0000);
    ack_done();
    drp_txn("again1", 7'h41, 1'b1, 16'h3F0F, 16'h0000);
    ack_done();
    drp_txn("again2", 7'h42, 1'b1, 16'h0400, 16'h0000);
    ack_done();
    check("again cfgdone", {31'd0, cfg_done_out}, 32'd1);

`ifdef DRP_TIMEOUT_EN
    // Silent responder on a read of channel 4.
    eoc_in     = 1'b1;
    channel_in = 5'd4;
    tick();
    eoc_in = 1'b0;
    check("to den", {31'd0, drp.den_out}, 32'd1);
    repeat (64) tick();
    check("to early", {31'd0, timeout_out}, 32'd0);
    tick();
    check("to pulse", {31'd0, timeout_out}, 32'd1);
    check("to no valid", {31'd0, sample_valid_out}, 32'd0);
    check("to idle", {31'd0, busy_out}, 32'd0);
    tick();
    check("to width", {31'd0, timeout_out}, 32'd0);
    eoc_in     = 1'b1;
    channel_in = 5'd4;
    tick();
    eoc_in = 1'b0;
    drp_txn("rd4", 7'h04, 1'b0, 16'h0000, 16'h4440);
    ack_done();
    check("rd4 valid", {31'd0, sample_valid_out}, 32'd1);
    check("rd4 sample", {20'd0, sample_out}, 32'h0444);
`else
    // Without the timeout a silent responder keeps the read outstanding.
    eoc_in     = 1'b1;
    channel_in = 5'd4;
    tick();
    eoc_in = 1'b0;
    repeat (80) tick();
    check("hold busy", {31'd0, busy_out}, 32'd1);
    check("hold timeout", {31'd0, timeout_out}, 32'd0);
    drp.drdy_in   = 1'b1;
    drp.drp_do_in = 16'h4440;
    ack_done();
    check("late valid", {31'd0, sample_valid_out}, 32'd1);
    check("late sample", {20'd0, sample_out}, 32'h0444);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
